// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Issues the (opcode, imm) instruction stream for the per-neuron controller.
//   A host loads a small program RAM through a write port while the sequencer
//   is not busy; a start pulse then steps the PC through the program, one
//   instruction per cycle. MACC-feed (M) words wait until either data FIFO is
//   non-empty, and the run ends on a halt (F) word or after the last RAM word.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   prog_we/addr/data  program RAM write port (data: [17:16] opcode, [15:0] imm)
//   start              1-cycle pulse, run from address 0 (ignored unless IDLE)
//   input_fifo_empty   input FIFO empty flag
//   work_fifo_empty    work FIFO empty flag
//   opcode, imm        registered issued instruction (bubble = 11 / 0)
//   busy               high in RUN and STALL
//   done               registered 1-cycle pulse when the program halts
//   pc                 current fetch address (debug)
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [17:0]       prog_data,
    input  logic              start,
    input  logic              input_fifo_empty,
    input  logic              work_fifo_empty,
    output logic [1:0]        opcode,
    output logic [15:0]       imm,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_M = 2'b01;
    localparam logic [1:0] OP_F = 2'b11;

    logic [17:0]       r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_op;
    logic [15:0]       r_imm;
    logic              r_done;

    logic [17:0]       w_word;
    logic              w_fifo_dry;
    logic              w_issue;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [1:0]        w_op_nxt;
    logic [15:0]       w_imm_nxt;
    logic              w_done_nxt;

    assign w_word     = r_mem[r_pc];
    assign w_fifo_dry = input_fifo_empty & work_fifo_empty;
    assign busy       = (r_state == S_RUN) || (r_state == S_STALL);

    // Writes are dropped while a program is running so the stream never
    // changes under the PC.
    always_ff @(posedge clk) begin
        if (prog_we && !busy)
            r_mem[prog_addr] <= prog_data;
    end

    // w_issue: forward the fetched word this cycle. In STALL the held word is
    // always an M, so only the FIFO flags matter.
    always_comb begin
        w_issue = 1'b0;
        case (r_state)
            S_RUN:   w_issue = (w_word[17:16] != OP_F) &&
                               !((w_word[17:16] == OP_M) && w_fifo_dry);
            S_STALL: w_issue = !w_fifo_dry;
            default: w_issue = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_op_nxt    = OP_F;     // bubble unless something is issued
        w_imm_nxt   = '0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN, S_STALL: begin
                if (w_issue) begin
                    w_op_nxt  = w_word[17:16];
                    w_imm_nxt = w_word[15:0];
                    // Running off the end of the RAM halts like an F word,
                    // with the PC parked on the last address.
                    if (r_pc == ADDR_W'(DEPTH - 1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pc_nxt    = r_pc + ADDR_W'(1);
                        w_state_nxt = S_RUN;
                    end
                end else if (r_state == S_RUN && w_word[17:16] == OP_F) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_STALL;
                end
            end
            default: w_state_nxt = S_IDLE;  // DONE lasts one cycle
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_op    <= OP_F;
            r_imm   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_op    <= w_op_nxt;
            r_imm   <= w_imm_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign opcode = r_op;
    assign imm    = r_imm;
    assign done   = r_done;
    assign pc     = r_pc;

endmodule
